// File: rtl/deserializador_patron_pkg.sv
// deserializador_patron_pkg: FSM encoding and word-width limits shared by the serial link blocks
package deserializador_patron_pkg;
  typedef enum logic {VACIO = 1'b0, PENDIENTE = 1'b1} estado_t;
  localparam int ANCHO_MIN = 2;
  localparam int ANCHO_MAX = 32;
  function automatic bit ancho_legal(int ancho);
    return ancho >= ANCHO_MIN && ancho <= ANCHO_MAX;
  endfunction
endpackage

// File: rtl/deserializador_patron_if.sv
// deserializador_patron_if: serial input side plus valid/ready word output of the deserializer
interface deserializador_patron_if #(parameter int ANCHO = 2);
  logic EntradaSerie;
  logic EntradaValida;
  logic Limpiar;
  logic [ANCHO-1:0] Salida;
  logic SalidaValida;
  logic SalidaLista;
  logic Coincide;
  logic Desborde;
  modport master (
    output EntradaSerie, EntradaValida, Limpiar, SalidaLista,
    input Salida, SalidaValida, Coincide, Desborde
  );
  modport slave (
    input EntradaSerie, EntradaValida, Limpiar, SalidaLista,
    output Salida, SalidaValida, Coincide, Desborde
  );
endinterface

// File: rtl/deserializador_patron_registro_desplazamiento.sv
// registro_desplazamiento: shift register with enable and sync clear; siguiente is the value it would take
module registro_desplazamiento #(
  parameter int ANCHO = 2,
  parameter bit MSB_PRIMERO = 1'b1
) (
  input logic clk,
  input logic rst_n,
  input logic en,
  input logic limpiar,
  input logic dato,
  output logic [ANCHO-1:0] siguiente
);
  logic [ANCHO-1:0] q;
  always_comb siguiente = MSB_PRIMERO ? {q[ANCHO-2:0], dato} : {dato, q[ANCHO-1:1]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (limpiar) q <= '0;
    else if (en) q <= siguiente;
endmodule

// File: rtl/deserializador_patron.sv
// deserializador_patron: collects ANCHO serial bits into a word, flags pattern match and overrun
module deserializador_patron
  import deserializador_patron_pkg::*;
#(
  parameter int ANCHO = 2,
  parameter logic [ANCHO-1:0] PATRON = ANCHO'(2'b11),
  parameter bit MSB_PRIMERO = 1'b1
) (
  input logic Reloj,
  input logic Reiniciar_n,
  deserializador_patron_if.slave bus
);
  localparam int CW = $clog2(ANCHO);
  estado_t estado, estado_sig;
  logic [CW-1:0] cuenta;
  logic [ANCHO-1:0] palabra;
  logic acepta, completa, consumo, cargar, descartar, vaciar;
  always_comb begin
    acepta = bus.EntradaValida && !bus.Limpiar;
    completa = acepta && cuenta == CW'(ANCHO - 1);
    consumo = estado == PENDIENTE && bus.SalidaLista;
  end
  registro_desplazamiento #(.ANCHO(ANCHO), .MSB_PRIMERO(MSB_PRIMERO)) u_registro (
    .clk(Reloj),
    .rst_n(Reiniciar_n),
    .en(acepta),
    .limpiar(bus.Limpiar),
    .dato(bus.EntradaSerie),
    .siguiente(palabra)
  );
  always_ff @(posedge Reloj or negedge Reiniciar_n)
    if (!Reiniciar_n) cuenta <= '0;
    else if (bus.Limpiar) cuenta <= '0;
    else if (acepta) cuenta <= completa ? '0 : cuenta + CW'(1);
  always_ff @(posedge Reloj or negedge Reiniciar_n)
    if (!Reiniciar_n) estado <= VACIO;
    else estado <= estado_sig;
  always_comb
    estado_sig = estado == VACIO ? (completa ? PENDIENTE : VACIO)
                                 : (consumo && !completa ? VACIO : PENDIENTE);
  // a word completing while the consumer takes the previous one replaces it with no bubble
  always_comb begin
    cargar = completa && (estado == VACIO || bus.SalidaLista);
    descartar = completa && estado == PENDIENTE && !bus.SalidaLista;
    vaciar = consumo && !completa;
  end
  always_ff @(posedge Reloj or negedge Reiniciar_n)
    if (!Reiniciar_n) begin
      bus.Salida <= '0;
      bus.Coincide <= 1'b0;
      bus.Desborde <= 1'b0;
    end else begin
      if (cargar) begin
        bus.Salida <= palabra;
        bus.Coincide <= palabra == PATRON;
      end else if (vaciar) bus.Coincide <= 1'b0;
      bus.Desborde <= bus.Limpiar ? 1'b0 : bus.Desborde || descartar;
    end
  always_comb bus.SalidaValida = estado == PENDIENTE;
endmodule

// File: tb/tb_deserializador_patron.sv
// tb_deserializador_patron: three configurations driven together, scoreboard checked by a negedge monitor
module tb_deserializador_patron;
  localparam int W[3] = '{2, 2, 8};
  localparam bit M[3] = '{1'b1, 1'b0, 1'b1};
  localparam logic [31:0] P[3] = '{32'h3, 32'h3, 32'hA5};
  typedef struct {int k; logic [31:0] w; logic m;} exp_t;
  logic clk, rst_n;
  logic ser[3], val[3], lim[3], lista[3];
  logic [31:0] sal[3];
  logic sv[3], coi[3], dsb[3];
  exp_t sb[$];
  int n_cmp, n_bad;
  int n[3];
  bit bits[3][32];
  bit cur_pend[3], nxt_pend[3], cur_ovf[3], nxt_ovf[3];
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int A = W[g];
    deserializador_patron_if #(.ANCHO(A)) b();
    deserializador_patron #(.ANCHO(A), .PATRON(A'(P[g])), .MSB_PRIMERO(M[g])) u_dut (
      .Reloj(clk),
      .Reiniciar_n(rst_n),
      .bus(b.slave)
    );
    assign b.EntradaSerie = ser[g];
    assign b.EntradaValida = val[g];
    assign b.Limpiar = lim[g];
    assign b.SalidaLista = lista[g];
    assign sal[g] = 32'(b.Salida);
    assign sv[g] = b.SalidaValida;
    assign coi[g] = b.Coincide;
    assign dsb[g] = b.Desborde;
  end
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(string nm, int k, logic [31:0] a, logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, k, a, e);
    end
  endtask
  task automatic mreset();
    sb.delete();
    for (int k = 0; k < 3; k++) begin
      n[k] = 0;
      cur_pend[k] = 0;
      nxt_pend[k] = 0;
      cur_ovf[k] = 0;
      nxt_ovf[k] = 0;
    end
  endtask
  // reference: collect bits in arrival order, place them by index once W[k] have arrived
  task automatic step(int k);
    bit hs, done;
    logic [31:0] word;
    hs = cur_pend[k] && lista[k];
    done = 0;
    word = '0;
    nxt_pend[k] = cur_pend[k];
    nxt_ovf[k] = cur_ovf[k];
    if (lim[k]) begin
      n[k] = 0;
      nxt_ovf[k] = 0;
    end else if (val[k]) begin
      bits[k][n[k]] = ser[k];
      n[k]++;
      if (n[k] == W[k]) begin
        done = 1;
        for (int i = 0; i < W[k]; i++) word[M[k] ? W[k] - 1 - i : i] = bits[k][i];
        n[k] = 0;
      end
    end
    if (done) begin
      if (!cur_pend[k] || lista[k]) begin
        sb.push_back('{k: k, w: word, m: word == P[k]});
        nxt_pend[k] = 1;
      end else nxt_ovf[k] = 1;
    end else if (hs) nxt_pend[k] = 0;
  endtask
  task automatic tick();
    for (int k = 0; k < 3; k++) step(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      cur_pend[k] = nxt_pend[k];
      cur_ovf[k] = nxt_ovf[k];
    end
  endtask
  task automatic send(int k, logic v);
    val[k] = 1'b1;
    ser[k] = v;
    tick();
    val[k] = 1'b0;
  endtask
  task automatic chk_zero();
    for (int k = 0; k < 3; k++) begin
      chk("rst_Salida", k, sal[k], 0);
      chk("rst_SalidaValida", k, sv[k], 0);
      chk("rst_Coincide", k, coi[k], 0);
      chk("rst_Desborde", k, dsb[k], 0);
    end
  endtask
  always @(negedge clk) begin
    int idx;
    if (rst_n) for (int k = 0; k < 3; k++) begin
      chk("SalidaValida", k, sv[k], cur_pend[k]);
      chk("Desborde", k, dsb[k], cur_ovf[k]);
      if (!sv[k]) chk("Coincide_idle", k, coi[k], 0);
      if (sv[k] && lista[k]) begin
        idx = -1;
        for (int i = 0; i < sb.size(); i++) if (idx < 0 && sb[i].k == k) idx = i;
        if (idx < 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word[%0d]: got %0h expected no word", k, sal[k]);
        end else begin
          chk("Salida", k, sal[k], sb[idx].w);
          chk("Coincide", k, coi[k], 32'(sb[idx].m));
          sb.delete(idx);
        end
      end
    end
  end
  initial begin
    logic [7:0] v;
    int left;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ser[k] = 0;
      val[k] = 0;
      lim[k] = 0;
      lista[k] = 1;
    end
    mreset();
    #12;
    chk_zero();
    rst_n = 1'b1;
    tick();
    tick();
    send(0, 1);
    #2 rst_n = 1'b0;
    #1 chk_zero();
    mreset();
    #2 rst_n = 1'b1;
    send(0, 1);
    send(0, 1);
    tick();
    tick();
    val[0] = 1; val[1] = 1; ser[0] = 1; ser[1] = 1;
    tick();
    ser[0] = 0; ser[1] = 0;
    tick();
    val[0] = 0; val[1] = 0;
    tick();
    tick();
    lista[0] = 0;
    send(0, 1); send(0, 1); send(0, 0); send(0, 1);
    tick();
    lim[0] = 1;
    tick();
    lim[0] = 0;
    tick();
    lista[0] = 1;
    tick();
    tick();
    lista[0] = 0;
    send(0, 1); send(0, 0); send(0, 1);
    lista[0] = 1;
    send(0, 1);
    tick();
    tick();
    send(0, 1);
    repeat (3) tick();
    val[0] = 1; ser[0] = 1; lim[0] = 1;
    tick();
    val[0] = 0; lim[0] = 0;
    send(0, 0); send(0, 1);
    tick();
    tick();
    v = 8'hA5;
    for (int i = 7; i >= 0; i--) send(2, v[i]);
    v = 8'h5A;
    for (int i = 7; i >= 0; i--) send(2, v[i]);
    tick();
    tick();
    repeat (3000) begin
      for (int k = 0; k < 3; k++) begin
        val[k] = $urandom_range(0, 9) < 7;
        ser[k] = 1'($urandom);
        lim[k] = $urandom_range(0, 19) == 0;
        lista[k] = $urandom_range(0, 9) < 6;
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      val[k] = 0;
      lim[k] = 0;
      lista[k] = 1;
    end
    repeat (5) tick();
    for (int k = 0; k < 3; k++) begin
      left = 0;
      foreach (sb[i]) if (sb[i].k == k) left++;
      chk("words_left", k, left, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/deserializador_patron.md
Name: deserializador_patron

Overview:
- Serial-to-parallel receiver. Collects ANCHO serial bits into one word and presents it on a valid/ready output.
- Flags when the completed word equals a fixed pattern; with the defaults this is the registered, sequential form of the 2-bit "both ones" detector.
- Sits between a bit-serial source (test stimulus, shift-register link) and parallel consumer logic.

Parameters:
- ANCHO, 2, bits per word; legal range 2..32.
- PATRON, 2'b11 (ANCHO bits), word value that asserts Coincide.
- MSB_PRIMERO, 1, 1 = first received bit lands in Salida[ANCHO-1]; 0 = first received bit lands in Salida[0].

Ports:
- Reloj  in  1  single clock; rising edge.
- Reiniciar_n  in  1  asynchronous active-low reset.
- EntradaSerie  in  1  serial data bit.
- EntradaValida  in  1  EntradaSerie is sampled on this edge.
- Limpiar  in  1  synchronous flush of the partial word and of Desborde.
- Salida  out  ANCHO  completed word.
- SalidaValida  out  1  Salida holds an unconsumed word.
- SalidaLista  in  1  consumer accepts the word when SalidaLista and SalidaValida are both 1.
- Coincide  out  1  Salida == PATRON; qualified by SalidaValida, otherwise 0.
- Desborde  out  1  sticky overrun flag.

Behaviour:
- Reset (async assert, sync release):
  - Salida=0, SalidaValida=0, Coincide=0, Desborde=0.
  - Bit counter=0, shift register=0, FSM=VACIO.
- Shift register and bit counter (0..ANCHO-1) advance only on edges where EntradaValida=1 and Limpiar=0.
  - MSB_PRIMERO=1: shift left, new bit into LSB.
  - MSB_PRIMERO=0: shift right, new bit into MSB.
- Word completion: an accepted bit while counter==ANCHO-1. The counter wraps to 0 on the same edge.
- FSM states: VACIO (no pending word) and PENDIENTE (word pending).
  - VACIO + completion -> load Salida. SalidaValida=1 and Coincide valid on the same edge as the last bit (1-cycle latency from the last bit's sample edge) -> PENDIENTE.
  - PENDIENTE + handshake, no completion -> SalidaValida=0, Coincide=0 -> VACIO.
  - PENDIENTE + handshake + completion on the same edge -> new word loaded, SalidaValida stays 1, stay PENDIENTE. No bubble, no overrun.
  - PENDIENTE + completion, no handshake -> new word discarded, Salida unchanged, Desborde set to 1 (sticky), stay PENDIENTE.
- Salida and Coincide are stable while SalidaValida=1 and no handshake occurs.
- Limpiar=1:
  - Clears counter, shift register and Desborde.
  - A bit presented on that edge is discarded; Limpiar has priority over EntradaValida.
  - Does not affect Salida, SalidaValida, Coincide or the FSM; a pending word survives.
- Gaps (EntradaValida=0) of any length leave all state unchanged.
- Reset asserted mid-word or mid-handshake: everything returns to reset values immediately; the partial word is lost.
- Coincide is computed from the word being loaded and registered with it; no combinational path from inputs to outputs.

Decomposition:
- Shared package: FSM state encoding (VACIO=1'b0, PENDIENTE=1'b1) and the ANCHO legal-range constants, for reuse by the matching serializer.
- One natural sub-module: registro_desplazamiento, a parameterised shift register with enable, synchronous clear and a direction parameter.
- Counter, FSM, output register and Desborde stay in the top module.

Test Plan:
- Reset mid-word: feed one bit (1), pulse Reiniciar_n low asynchronously, then feed 1,1 -> all outputs 0 during reset; Salida=2'b11, SalidaValida=1, Coincide=1 one edge after the 2nd post-reset bit.
- Default params, SalidaLista=1, bits 1,0 -> Salida=2'b10, Coincide=0, SalidaValida high for exactly 1 cycle. Repeat with MSB_PRIMERO=0 -> Salida=2'b01.
- Back-pressure, SalidaLista=0, bits 1,1,0,1 -> Salida stays 2'b11, Coincide=1, Desborde=1 after the 4th bit. Pulse Limpiar -> Desborde=0, SalidaValida still 1.
- Simultaneous completion and consume: word 2'b10 pending, SalidaLista=1 on the edge the next word 1,1 completes -> SalidaValida stays 1, Salida=2'b11, Desborde=0.
- Gaps and flush: bit 1, three idle cycles, Limpiar together with EntradaValida (bit 1), then bits 0,1 -> Salida=2'b01; the flushed bits never appear.
- ANCHO=8, PATRON=8'hA5: stream 8'hA5 then 8'h5A MSB-first with SalidaLista=1 -> Coincide=1 for the first word, 0 for the second.
